// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- single-outstanding load/store unit controller
//
// Accepts one load/store request from the pipeline and checks it for
// alignment and legal size encoding. Legal requests run one registered
// memory access. Store data is lane-placed on the way out. Load data is
// lane-extracted and sign/zero-extended on the way back. Every accepted
// request ends with exactly one resp_valid pulse.
//
// Parameters
//   ACK_TIMEOUT   cycles spent in ACCESS waiting for mem_ack before the access
//                 is abandoned with resp_err (legal 1..255)
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_valid / req_ready            request handshake (ready only in IDLE)
//   req_we, req_funct3               store/load select, size/sign encoding
//   req_addr, req_wdata              byte address, right-justified store data
//   mem_req, mem_we, mem_addr,       registered memory request, word-aligned
//   mem_wdata, mem_be                address, lane-placed data, byte enables
//   mem_ack, mem_rdata               memory completion and read data
//   resp_valid, resp_rdata,          response pulse, extended load data,
//   resp_misalign, resp_err          illegal-request flag, timeout flag
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_err
);

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // A request is illegal when its size does not match the address alignment,
  // when the size encoding is unused, or when a store asks for an unsigned
  // size (only loads have a signedness).
  function automatic logic req_illegal(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (funct3)
      3'b000:  bad = 1'b0;
      3'b100:  bad = we;
      3'b001:  bad = off[0];
      3'b101:  bad = we | off[0];
      3'b010:  bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replicate the right-justified store data across every lane; the byte
  // enables pick out the lane that memory actually writes.
  function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0]        funct3,
                                                    input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] lanes;
    case (funct3[1:0])
      2'b00:   lanes = {4{wdata[7:0]}};
      2'b01:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  // Loads always read the whole word; extraction happens on the way back.
  function automatic logic [3:0] store_be(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic [3:0] be;
    if (!we) begin
      be = 4'b1111;
    end else begin
      case (funct3[1:0])
        2'b00:   be = 4'b0001 << off;
        2'b01:   be = 4'b0011 << {off[1], 1'b0};
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [DATA_W-1:0] load_extract(input logic [2:0]        funct3,
                                                     input logic [1:0]        off,
                                                     input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0]        sh_b;
    logic [DATA_W-1:0]        sh_h;
    logic signed [7:0]        b_s;
    logic signed [15:0]       h_s;
    logic signed [DATA_W-1:0] ext_s;
    logic [DATA_W-1:0]        res;
    sh_b  = rdata >> {off, 3'b000};
    sh_h  = rdata >> {off[1], 4'b0000};
    b_s   = $signed(sh_b[7:0]);
    h_s   = $signed(sh_h[15:0]);
    ext_s = '0;
    res   = '0;
    case (funct3)
      3'b000: begin
        ext_s = 32'(b_s);
        res   = $unsigned(ext_s);
      end
      3'b001: begin
        ext_s = 32'(h_s);
        res   = $unsigned(ext_s);
      end
      3'b100:  res = {24'd0, sh_b[7:0]};
      3'b101:  res = {16'd0, sh_h[15:0]};
      3'b010:  res = rdata;
      default: res = '0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_inc;

  // Request fields kept for the response path
  logic       req_we_p0;
  logic [2:0] req_funct3_p0;
  logic [1:0] req_off_p0;

  assign wait_cnt_inc = wait_cnt + 8'd1;
  assign req_ready    = (state == S_IDLE);
  assign resp_valid   = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= 8'd0;
      req_we_p0     <= 1'b0;
      req_funct3_p0 <= 3'd0;
      req_off_p0    <= 2'd0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= 4'd0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      case (state)
        // ---- IDLE -> ACCESS / RESP ----
        S_IDLE: begin
          if (req_valid) begin
            req_we_p0     <= req_we;
            req_funct3_p0 <= req_funct3;
            req_off_p0    <= req_addr[1:0];
            if (req_illegal(req_we, req_funct3, req_addr[1:0])) begin
              // Illegal requests never touch memory; answer directly.
              state         <= S_RESP;
              resp_misalign <= 1'b1;
              resp_err      <= 1'b0;
              resp_rdata    <= '0;
            end else begin
              state     <= S_ACCESS;
              wait_cnt  <= 8'd0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_we ? store_lanes(req_funct3, req_wdata) : '0;
              mem_be    <= store_be(req_we, req_funct3, req_addr[1:0]);
            end
          end
        end

        // ---- ACCESS -> RESP ----
        S_ACCESS: begin
          if (mem_ack) begin
            state         <= S_RESP;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            resp_misalign <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= req_we_p0 ? '0
                             : load_extract(req_funct3_p0, req_off_p0, mem_rdata);
          end else begin
            wait_cnt <= wait_cnt_inc;
            // wait_cnt_inc counts ACCESS cycles spent so far, including this one.
            if (wait_cnt_inc == TIMEOUT_CNT) begin
              state         <= S_RESP;
              mem_req       <= 1'b0;
              mem_we        <= 1'b0;
              resp_misalign <= 1'b0;
              resp_err      <= 1'b1;
              resp_rdata    <= '0;
            end
          end
        end

        // ---- RESP -> IDLE ----
        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_err;

  int checks;
  int failures;

  lsu_ctrl #(.ACK_TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .resp_err      (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    tick();
    req_valid  = 1'b0;
  endtask

  int cnt;
  int pulses;
  logic err_seen;
  logic [31:0] rd_seen;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;

    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_flags", {resp_misalign, resp_err}, 0);

    // Signed byte load, ack in first ACCESS cycle
    issue(1'b0, 3'b000, 32'h0000_1003, 32'd0);
    chk("lb_mem_req", mem_req, 1);
    chk("lb_mem_addr", mem_addr, 32'h0000_1000);
    chk("lb_mem_be", mem_be, 4'hF);
    chk("lb_mem_we", mem_we, 0);
    chk("lb_req_ready_busy", req_ready, 0);
    chk("lb_no_early_resp", resp_valid, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'h80FF_1234;
    tick();
    mem_ack = 1'b0;
    chk("lb_resp_valid", resp_valid, 1);
    chk("lb_resp_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("lb_flags", {resp_misalign, resp_err}, 0);
    chk("lb_mem_req_drop", mem_req, 0);
    tick();
    chk("lb_resp_one_pulse", resp_valid, 0);
    chk("lb_ready_again", req_ready, 1);
    chk("lb_rdata_hold", resp_rdata, 32'hFFFF_FF80);

    // mem_ack while IDLE is ignored
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_no_resp", resp_valid, 0);
    chk("idle_ack_no_req", mem_req, 0);
    chk("idle_ack_rdata_hold", resp_rdata, 32'hFFFF_FF80);

    // Unsigned half load, ack after 3 wait cycles; req_valid during ACCESS ignored
    issue(1'b0, 3'b101, 32'h0000_2002, 32'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        req_valid = 1'b1;
        req_addr = 32'hDEAD_0000;
      end
      if (i == 2) req_valid = 1'b0;
      if (i == 3) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hBEEF_0000;
      end
      if (mem_req) cnt++;
      chk("lhu_addr_hold", mem_addr, 32'h0000_2000);
      tick();
    end
    mem_ack = 1'b0;
    chk("lhu_mem_req_cycles", cnt, 4);
    chk("lhu_resp_valid", resp_valid, 1);
    chk("lhu_resp_rdata", resp_rdata, 32'h0000_BEEF);
    chk("lhu_mem_req_drop", mem_req, 0);
    tick();

    // Half store at upper half
    issue(1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD);
    chk("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
    chk("sh_mem_be", mem_be, 4'b1100);
    chk("sh_mem_we", mem_we, 1);
    chk("sh_mem_addr", mem_addr, 32'h0000_3000);
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("sh_resp_valid", resp_valid, 1);
    chk("sh_resp_rdata", resp_rdata, 0);
    tick();

    // Byte store at lane 1
    issue(1'b1, 3'b000, 32'h0000_5001, 32'h0000_00A5);
    chk("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_mem_be", mem_be, 4'b0010);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();

    // Signed half load at lower half
    issue(1'b0, 3'b001, 32'h0000_6000, 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_8001;
    tick();
    mem_ack = 1'b0;
    chk("lh_resp_rdata", resp_rdata, 32'hFFFF_8001);
    tick();

    // Word load
    issue(1'b0, 3'b010, 32'h0000_7000, 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    chk("lw_resp_rdata", resp_rdata, 32'hCAFE_F00D);
    tick();

    // Misaligned word load
    issue(1'b0, 3'b010, 32'h0000_4001, 32'd0);
    chk("mis_lw_no_mem_req", mem_req, 0);
    chk("mis_lw_resp_valid", resp_valid, 1);
    chk("mis_lw_misalign", resp_misalign, 1);
    chk("mis_lw_rdata", resp_rdata, 0);
    tick();
    chk("mis_lw_pulse_end", resp_valid, 0);
    chk("mis_lw_flag_hold", resp_misalign, 1);

    // Store with unsigned size encoding is illegal
    issue(1'b1, 3'b100, 32'h0000_4000, 32'h0000_0011);
    chk("mis_sbu_no_mem_req", mem_req, 0);
    chk("mis_sbu_resp_valid", resp_valid, 1);
    chk("mis_sbu_misalign", resp_misalign, 1);
    tick();

    // Unused funct3 encoding
    issue(1'b0, 3'b011, 32'h0000_4000, 32'd0);
    chk("mis_f3_011_no_mem_req", mem_req, 0);
    chk("mis_f3_011_misalign", resp_misalign, 1);
    tick();

    // Timeout: no ack ever
    issue(1'b0, 3'b010, 32'h0000_8000, 32'd0);
    cnt = 0;
    pulses = 0;
    err_seen = 1'b0;
    rd_seen = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) cnt++;
      if (resp_valid) begin
        pulses++;
        err_seen = resp_err;
        rd_seen = resp_rdata;
      end
      tick();
    end
    chk("to_mem_req_cycles", cnt, 16);
    chk("to_resp_pulses", pulses, 1);
    chk("to_resp_err", err_seen, 1);
    chk("to_resp_rdata", rd_seen, 0);

    // Reset in second ACCESS cycle
    issue(1'b0, 3'b010, 32'h0000_9000, 32'd0);
    chk("rstmid_mem_req_a1", mem_req, 1);
    tick();
    chk("rstmid_mem_req_a2", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_req_ready", req_ready, 1);
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_resp_valid", resp_valid, 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) pulses++;
      tick();
    end
    chk("rstmid_no_pulse", pulses, 0);

    issue(1'b0, 3'b010, 32'h0000_A000, 32'd0);
    chk("post_rst_mem_req", mem_req, 1);
    chk("post_rst_mem_addr", mem_addr, 32'h0000_A000);
    mem_ack = 1'b1;
    mem_rdata = 32'h1122_3344;
    tick();
    mem_ack = 1'b0;
    chk("post_rst_resp_valid", resp_valid, 1);
    chk("post_rst_resp_rdata", resp_rdata, 32'h1122_3344);
    chk("post_rst_flags", {resp_misalign, resp_err}, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, SHALL set the cycles waited in ACCESS for mem_ack before aborting (legal 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: one clock; synchronous, active-high.
REQ-004 req_valid  input  1  SHALL flag a pipeline load/store request.
REQ-005 req_ready  output  1  SHALL flag that the block accepts a request this cycle.
REQ-006 req_we  input  1  SHALL select store (1) or load (0).
REQ-007 req_funct3  input  3  SHALL encode size: 000 byte, 001 half, 010 word, 100 unsigned byte, 101 unsigned half.
REQ-008 req_addr  input  32  SHALL give the byte address; req_wdata  input  32  SHALL give store data, right-justified.
REQ-009 mem_req  output  1  SHALL request a memory access; mem_we  output  1  SHALL mark it a write.
REQ-010 mem_addr  output  32  SHALL be word-aligned ({req_addr[31:2],2'b00}); mem_wdata  output  32  SHALL carry lane-placed data; mem_be  output  4  SHALL carry byte enables.
REQ-011 mem_ack  input  1  SHALL complete the access; mem_rdata  input  32  SHALL be valid in the mem_ack cycle.
REQ-012 resp_valid  output  1  SHALL pulse one cycle per accepted request; resp_rdata  output  32; resp_misalign  output  1; resp_err  output  1.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 IDLE, req_valid=1: request SHALL be latched (addr, we, funct3, wdata); next state ACCESS if legal, RESP with resp_misalign=1 otherwise.
REQ-015 Illegal: half with addr[0]=1; word with addr[1:0]!=0; funct3 011/110/111; any store with funct3[2]=1. No memory access SHALL occur for illegal requests.
REQ-016 mem_req, mem_we, mem_addr, mem_wdata, mem_be SHALL be registered, asserted from the first ACCESS cycle and held stable until mem_ack or timeout.
REQ-017 Store lanes: byte -> wdata {4{b}}, be 4'b0001<<addr[1:0]; half -> {2{h}}, be 4'b0011<<(2*addr[1]); word -> wdata, be 4'b1111. Loads SHALL drive be 4'b1111.
REQ-018 Load data: byte lane = mem_rdata>>(8*addr[1:0]), half lane = mem_rdata>>(16*addr[1]); sign-extend for 000/001, zero-extend for 100/101, word unchanged; registered into resp_rdata on mem_ack.
REQ-019 ACCESS, mem_ack=1: mem_req SHALL drop next cycle, state -> RESP.
REQ-020 8-bit wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack; at ACK_TIMEOUT without ack, mem_req drops, resp_err=1, state -> RESP.
REQ-021 RESP SHALL last exactly one cycle with resp_valid=1, then -> IDLE; resp_rdata SHALL be 0 for stores, misaligned or timed-out requests.
REQ-022 resp_misalign, resp_err, resp_rdata SHALL hold until the next RESP; only valid with resp_valid.
REQ-023 Latency: accept at cycle N, mem_req at N+1, ack at N+1+k -> resp_valid at N+2+k; misaligned: resp_valid at N+1.
REQ-024 mem_ack outside ACCESS SHALL be ignored; req_valid outside IDLE SHALL be ignored (not latched).

Reset
REQ-025 rst=1 SHALL force IDLE in the next cycle, from any state including mid-ACCESS, with mem_req abandoned.
REQ-026 Reset values: req_ready=1 once in IDLE; mem_req, mem_we, resp_valid, resp_misalign, resp_err = 0; mem_addr, mem_wdata, resp_rdata = 0; mem_be = 0; wait counter = 0.

Verification
REQ-027 Load byte signed, addr 0x1003, mem_rdata 0x80FF_1234, ack same cycle -> mem_addr 0x1000, resp_rdata 0xFFFF_FF80, resp_valid 2 cycles after accept.
REQ-028 Load half unsigned, addr 0x2002, mem_rdata 0xBEEF_0000, ack after 3 waits -> resp_rdata 0x0000_BEEF, mem_req held 4 cycles.
REQ-029 Store half, addr 0x3002, wdata 0x0000_ABCD -> mem_wdata 0xABCD_ABCD, mem_be 4'b1100, mem_we=1, resp_rdata 0.
REQ-030 Load word, addr 0x4001 -> no mem_req, resp_misalign=1 one cycle after accept; store funct3 100 -> same.
REQ-031 Load word, mem_ack never asserted, ACK_TIMEOUT=16 -> mem_req drops after 16 cycles, resp_err=1, resp_valid one pulse.
REQ-032 rst in second ACCESS cycle -> next cycle IDLE, mem_req=0, resp_valid never pulses; following request completes normally.
